flag_control_unit: RTL and testbench

FLAG_CONTROL_UNIT -- requirements
Module: flag_control_unit

---
 rtl/flag_control_unit.sv | 186 ++++++++++++++++++
 tb/tb_flag_control_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/flag_control_unit.sv
// ---------------------------------------------------------------------------
// flag_control_unit
// Purpose: selects the next Z/N/C flag-register values from the ALU, the
//          jump-clear path or a LIFO flag stack used across interrupts, and
//          produces the conditional-branch decision.
//
// Parameters:
//   STACK_DEPTH        number of flag-save entries (2..16)
//
// Ports:
//   i_clk              clock, all state updates on the rising edge
//   i_rst              synchronous active-high reset
//   i_cur_*            current flag-register outputs (Z, N, C)
//   i_alu_*            flags produced by the ALU (Z, N, C)
//   i_alu_flag_we[2:0] per-flag ALU update mask {Z,N,C}
//   i_jump_en          conditional jump in execute
//   i_jump_cond[1:0]   00 = always, 01 = JZ, 10 = JN, 11 = JC
//   i_int_save         interrupt entry: push current flags
//   i_rti_restore      return from interrupt: pop flags
//   i_stall            freezes the stage (no flag change, no branch, no stack op)
//   o_next_*           flag-register inputs (combinational)
//   o_take_branch      branch decision (combinational)
//   o_stack_full/empty stack occupancy, decoded from the count register
//   o_stack_err        sticky stack error
//
// Configuration:
//   FLAG_STACK_ERR_EN  when defined, o_stack_err latches on push-when-full,
//                      restore-when-empty or simultaneous save+restore;
//                      otherwise o_stack_err is tied low.
// ---------------------------------------------------------------------------
module flag_control_unit #(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cur_zero,
    input  logic       i_cur_negative,
    input  logic       i_cur_carry,
    input  logic       i_alu_zero,
    input  logic       i_alu_negative,
    input  logic       i_alu_carry,
    input  logic [2:0] i_alu_flag_we,
    input  logic       i_jump_en,
    input  logic [1:0] i_jump_cond,
    input  logic       i_int_save,
    input  logic       i_rti_restore,
    input  logic       i_stall,
    output logic       o_next_zero,
    output logic       o_next_negative,
    output logic       o_next_carry,
    output logic       o_take_branch,
    output logic       o_stack_full,
    output logic       o_stack_empty,
    output logic       o_stack_err
);

    localparam int unsigned CW = $clog2(STACK_DEPTH) + 1;
    localparam int unsigned IW = $clog2(STACK_DEPTH);

    // Stack storage and occupancy
    logic [2:0]    r_stack [STACK_DEPTH];
    logic [CW-1:0] r_count;

    logic [2:0]    w_cur;
    logic [2:0]    w_alu;
    logic [2:0]    w_merged;
    logic [2:0]    w_jump_clr;
    logic [2:0]    w_alu_path;
    logic [2:0]    w_top;
    logic [2:0]    w_next;
    logic [IW-1:0] w_top_idx;
    logic          w_empty;
    logic          w_full;
    logic          w_cond_true;
    logic          w_take;
    logic          w_save_req;
    logic          w_rest_req;
    logic          w_rest_only;
    logic          w_push;
    logic          w_pop;

    assign w_cur = {i_cur_zero, i_cur_negative, i_cur_carry};
    assign w_alu = {i_alu_zero, i_alu_negative, i_alu_carry};

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(STACK_DEPTH));

    // Stack requests only count when the stage is not stalled
    assign w_save_req  = i_int_save    & ~i_stall;
    assign w_rest_req  = i_rti_restore & ~i_stall;
    assign w_rest_only = w_rest_req & ~i_int_save;
    assign w_push      = w_save_req & ~i_rti_restore & ~w_full;
    assign w_pop       = w_rest_only & ~w_empty;

    // Top-of-stack index; clamped to 0 when empty so it never leaves the array
    assign w_top_idx = w_empty ? '0 : IW'(r_count - CW'(1));
    assign w_top     = r_stack[w_top_idx];

    // Branch condition decode
    always_comb begin
        w_cond_true = 1'b0;
        case (i_jump_cond)
            2'b00:   w_cond_true = 1'b1;
            2'b01:   w_cond_true = i_cur_zero;
            2'b10:   w_cond_true = i_cur_negative;
            default: w_cond_true = i_cur_carry;
        endcase
    end

    assign w_take = i_jump_en & w_cond_true & ~i_stall;

    // A taken conditional jump clears the flag it tested
    always_comb begin
        w_jump_clr = 3'b000;
        if (w_take) begin
            case (i_jump_cond)
                2'b01:   w_jump_clr = 3'b100;
                2'b10:   w_jump_clr = 3'b010;
                2'b11:   w_jump_clr = 3'b001;
                default: w_jump_clr = 3'b000;
            endcase
        end
    end

    assign w_merged   = (w_alu & i_alu_flag_we) | (w_cur & ~i_alu_flag_we);
    assign w_alu_path = w_merged & ~w_jump_clr;

    // Next-flag select: stall holds, pop wins, empty restore holds, else ALU/jump
    always_comb begin
        w_next = w_cur;
        if (!i_stall) begin
            if (w_pop) begin
                w_next = w_top;
            end else if (w_rest_only) begin
                w_next = w_cur;
            end else begin
                w_next = w_alu_path;
            end
        end
    end

    assign o_next_zero     = w_next[2];
    assign o_next_negative = w_next[1];
    assign o_next_carry    = w_next[0];
    assign o_take_branch   = w_take;
    assign o_stack_full    = w_full;
    assign o_stack_empty   = w_empty;

    // Stack and count update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                r_stack[i] <= 3'b000;
            end
        end else if (w_push) begin
            r_stack[IW'(r_count)] <= w_cur;
            r_count               <= r_count + CW'(1);
        end else if (w_pop) begin
            r_count <= r_count - CW'(1);
        end
    end

`ifdef FLAG_STACK_ERR_EN
    logic w_err;
    logic r_stack_err;

    assign w_err = (w_save_req & w_rest_req)
                 | (w_save_req & ~i_rti_restore & w_full)
                 | (w_rest_only & w_empty);

    // Sticky error, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stack_err <= 1'b0;
        end else if (w_err) begin
            r_stack_err <= 1'b1;
        end
    end

    assign o_stack_err = r_stack_err;
`else
    assign o_stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_flag_control_unit.sv
// ---------------------------------------------------------------------------
// tb_flag_control_unit: directed vectors with a scoreboard queue; a monitor
// samples the DUT on the falling edge and compares against queued
// expectations. Default STACK_DEPTH = 4.
// ---------------------------------------------------------------------------
module tb_flag_control_unit;

`ifdef FLAG_STACK_ERR_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       cur_z, cur_n, cur_c;
    logic       alu_z, alu_n, alu_c;
    logic [2:0] we;
    logic       jen;
    logic [1:0] jcond;
    logic       save, rest, stall;
    logic       nz, nn, nc, take, full, empty, err;

    // {next[2:0], take, full, empty, err}
    logic [6:0] exp_q [$];
    string      name_q [$];
    logic       done;

    int checks;
    int errors;

    flag_control_unit #(.STACK_DEPTH(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cur_zero     (cur_z),
        .i_cur_negative (cur_n),
        .i_cur_carry    (cur_c),
        .i_alu_zero     (alu_z),
        .i_alu_negative (alu_n),
        .i_alu_carry    (alu_c),
        .i_alu_flag_we  (we),
        .i_jump_en      (jen),
        .i_jump_cond    (jcond),
        .i_int_save     (save),
        .i_rti_restore  (rest),
        .i_stall        (stall),
        .o_next_zero    (nz),
        .o_next_negative(nn),
        .o_next_carry   (nc),
        .o_take_branch  (take),
        .o_stack_full   (full),
        .o_stack_empty  (empty),
        .o_stack_err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue its expected response
    task automatic vec(input string nm, input logic [2:0] cur, input logic [2:0] alu,
                       input logic [2:0] msk, input logic j_en, input logic [1:0] j_cond,
                       input logic s, input logic r, input logic st, input logic rs,
                       input logic [2:0] x_next, input logic x_take, input logic x_full,
                       input logic x_empty, input logic x_err);
        {cur_z, cur_n, cur_c} = cur;
        {alu_z, alu_n, alu_c} = alu;
        we    = msk;
        jen   = j_en;
        jcond = j_cond;
        save  = s;
        rest  = r;
        stall = st;
        rst   = rs;
        exp_q.push_back({x_next, x_take, x_full, x_empty, x_err});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        done = 1'b0;
        {cur_z, cur_n, cur_c, alu_z, alu_n, alu_c} = '0;
        we = '0; jen = 0; jcond = '0; save = 0; rest = 0; stall = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        //    name               cur     alu     mask    je cond   sv rt st rs   next    tk fu em er
        vec("reset_idle",      3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0);
        vec("alu_101",         3'b000, 3'b111, 3'b101, 0, 2'b00, 0, 0, 0, 0, 3'b101, 0, 0, 1, 0);
        vec("alu_mix",         3'b110, 3'b001, 3'b011, 0, 2'b00, 0, 0, 0, 0, 3'b101, 0, 0, 1, 0);
        vec("jz_taken",        3'b100, 3'b100, 3'b100, 1, 2'b01, 0, 0, 0, 0, 3'b000, 1, 0, 1, 0);
        vec("jz_not_taken",    3'b011, 3'b111, 3'b111, 1, 2'b01, 0, 0, 0, 0, 3'b111, 0, 0, 1, 0);
        vec("jn_taken",        3'b011, 3'b101, 3'b101, 1, 2'b10, 0, 0, 0, 0, 3'b101, 1, 0, 1, 0);
        vec("jc_taken",        3'b001, 3'b000, 3'b000, 1, 2'b11, 0, 0, 0, 0, 3'b000, 1, 0, 1, 0);
        vec("jmp_uncond",      3'b010, 3'b101, 3'b111, 1, 2'b00, 0, 0, 0, 0, 3'b101, 1, 0, 1, 0);
        vec("jen_off",         3'b100, 3'b000, 3'b000, 0, 2'b01, 0, 0, 0, 0, 3'b100, 0, 0, 1, 0);
        // save / restore
        vec("save_101",        3'b101, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b101, 0, 0, 1, 0);
        vec("save_010",        3'b010, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b010, 0, 0, 0, 0);
        vec("rest_010",        3'b111, 3'b000, 3'b111, 0, 2'b00, 0, 1, 0, 0, 3'b010, 0, 0, 0, 0);
        vec("rest_101",        3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 1, 0, 0, 3'b101, 0, 0, 0, 0);
        vec("empty_after",     3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0);
        vec("rest_empty",      3'b110, 3'b001, 3'b111, 0, 2'b00, 0, 1, 0, 0, 3'b110, 0, 0, 1, 0);
        vec("err_rest_empty",  3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, E);
        vec("rst_clear_err",   3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 1, 3'b000, 0, 0, 1, E);
        vec("post_rst",        3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0);
        // simultaneous save and restore at count 2
        vec("both_pre_a",      3'b101, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b101, 0, 0, 1, 0);
        vec("both_pre_b",      3'b010, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b010, 0, 0, 0, 0);
        vec("save_rest_both",  3'b110, 3'b001, 3'b001, 0, 2'b00, 1, 1, 0, 0, 3'b111, 0, 0, 0, 0);
        vec("both_err",        3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, E);
        vec("both_rest_a",     3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 1, 0, 0, 3'b010, 0, 0, 0, E);
        vec("both_rest_b",     3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 1, 0, 0, 3'b101, 0, 0, 0, E);
        vec("rst_again",       3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 1, 3'b000, 0, 0, 1, E);
        vec("post_rst2",       3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0);
        // overflow: five pushes into a depth-4 stack
        vec("push1",           3'b001, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b001, 0, 0, 1, 0);
        vec("push2",           3'b010, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b010, 0, 0, 0, 0);
        vec("push3",           3'b011, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b011, 0, 0, 0, 0);
        vec("push4",           3'b100, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b100, 0, 0, 0, 0);
        vec("push5_drop",      3'b111, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b111, 0, 1, 0, 0);
        vec("ovf_full_err",    3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 1, 0, E);
        vec("ovf_top",         3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 1, 0, 0, 3'b100, 0, 1, 0, E);
        // stall with save + JZ pending (count 3)
        vec("stall_save_jz",   3'b100, 3'b011, 3'b111, 1, 2'b01, 1, 0, 1, 0, 3'b100, 0, 0, 0, E);
        vec("stall_no_push",   3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, E);
        vec("stall_rest",      3'b010, 3'b111, 3'b111, 0, 2'b00, 0, 1, 1, 0, 3'b010, 0, 0, 0, E);
        vec("rest_after_stall",3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 1, 0, 0, 3'b011, 0, 0, 0, E);
        vec("push_to_3",       3'b110, 3'b000, 3'b000, 0, 2'b00, 1, 0, 0, 0, 3'b110, 0, 0, 0, E);
        // reset with 3 entries and save+restore in the same cycle
        vec("rst_save_rest",   3'b000, 3'b000, 3'b000, 0, 2'b00, 1, 1, 0, 1, 3'b000, 0, 0, 0, E);
        vec("rest_after_rst",  3'b101, 3'b010, 3'b111, 0, 2'b00, 0, 1, 0, 0, 3'b101, 0, 0, 1, 0);
        vec("final_err",       3'b000, 3'b000, 3'b000, 0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 1, E);
        done = 1'b1;
    end

    // Monitor / scoreboard: owns the counters and ends the run
    initial begin
        logic [6:0] x;
        logic [6:0] act;
        string      nm;
        int         cyc;
        int         drain;
        checks = 0;
        errors = 0;
        cyc    = 0;
        drain  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {nz, nn, nc, take, full, empty, err};
                checks++;
                if (act !== x) begin
                    errors++;
                    $display("FAIL %s: got next=%b take=%b full=%b empty=%b err=%b, expected next=%b take=%b full=%b empty=%b err=%b",
                             nm, act[6:4], act[3], act[2], act[1], act[0],
                             x[6:4], x[3], x[2], x[1], x[0]);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $finish;
                end
                drain++;
                if (drain > 10) begin
                    errors++;
                    $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $finish;
                end
            end
            if (cyc > 2000) begin
                errors++;
                $display("FAIL watchdog: cycle %0d reached, expected completion before 2000", cyc);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

endmodule
